// File: rtl/session_controller.sv
// session_controller: login, lockout, menu and mode dispatch sequencer gating the shared buttons
module session_controller #(
    parameter int ID_W           = 16,
    parameter int SW_W           = 18,
    parameter int NUM_MODES      = 2,
    parameter int MSEL_W         = 3,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RESP_TIMEOUT   = 255,
    parameter int IDLE_TIMEOUT   = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW_W-1:0]      switches,
    input  logic [2:0]           buttons,
    input  logic                 access_valid,
    input  logic                 access_ok,
    input  logic [NUM_MODES-1:0] mode_done,
    output logic [ID_W-1:0]      pw_data,
    output logic                 pw_load,
    output logic [ID_W-1:0]      user_id,
    output logic [NUM_MODES-1:0] mode_sel,
    output logic [2:0]           btn_route,
    output logic [2:0]           lcd_code,
    output logic [3:0]           led_code,
    output logic                 locked
);
    typedef enum logic [2:0] {IDLE, AUTH, WAIT, LOCKOUT, MENU, RUN} state_t;
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int RW = $clog2(RESP_TIMEOUT + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int CW = LW > RW ? (LW > IW ? LW : IW) : (RW > IW ? RW : IW);
    state_t state, state_n;
    logic [2:0] prev, rise;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] fail, fail_n;
    logic [MSEL_W-1:0] k, k_n;
    logic bad, bad_n, load_n;
    logic [ID_W-1:0] pw_n, uid_n;
    logic [NUM_MODES-1:0] sel_n;
    logic [2:0] route_n, lcd_n;
    logic [3:0] led_n;
    logic unused;
    assign unused = ^switches;
    always_comb begin
        rise = buttons & ~prev;
        state_n = state;
        cnt_n = &cnt ? cnt : cnt + 1'b1;
        fail_n = fail;
        k_n = k;
        bad_n = bad;
        pw_n = pw_data;
        uid_n = user_id;
        load_n = 1'b0;
        case (state)
            IDLE: if (rise[0]) state_n = AUTH;
            AUTH: if (rise[0]) begin
                pw_n = switches[ID_W-1:0];
                uid_n = switches[ID_W-1:0];
                load_n = 1'b1;
                state_n = WAIT;
            end
            WAIT: if (access_valid && access_ok) begin
                fail_n = '0;
                state_n = MENU;
            end else if (access_valid || cnt == CW'(RESP_TIMEOUT)) begin
                fail_n = &fail ? fail : fail + 1'b1;
                state_n = fail_n == FW'(MAX_TRIES) ? LOCKOUT : AUTH;
            end
            LOCKOUT: if (cnt == CW'(LOCKOUT_CYCLES - 1)) begin
                fail_n = '0;
                state_n = AUTH;
            end
            MENU: begin
                if (|rise) bad_n = 1'b0;
                if (rise[0]) begin
                    uid_n = '0;
                    state_n = IDLE;
                end else if (rise[1]) begin
                    if (int'(switches[MSEL_W-1:0]) < NUM_MODES) begin
                        k_n = switches[MSEL_W-1:0];
                        state_n = RUN;
                    end else bad_n = 1'b1;
                end else if (rise[2]) begin
                    k_n = '0;
                    state_n = RUN;
                end else if (cnt == CW'(IDLE_TIMEOUT)) begin
                    uid_n = '0;
                    state_n = IDLE;
                end
            end
            RUN: if (|(mode_done & mode_sel)) state_n = MENU;
            default: state_n = IDLE;
        endcase
        // every counter restarts from zero on state entry; MENU also restarts on any edge
        if (state_n != state || (state == MENU && |rise)) cnt_n = '0;
        if (state_n != MENU) bad_n = 1'b0;
        sel_n = state_n == RUN ? NUM_MODES'(1) << k_n : '0;
        route_n = state_n == RUN ? 3'(k_n) + 3'd1 : 3'd0;
        lcd_n = state_n == IDLE ? 3'd0 : (state_n == AUTH || state_n == WAIT) ? 3'd1 :
                state_n == LOCKOUT ? 3'd4 : state_n == MENU ? (bad_n ? 3'd6 : 3'd3) : 3'd5;
        led_n = state_n == LOCKOUT ? 4'd8 : (state_n == MENU || state_n == RUN) ? 4'd2 :
                ((state_n == AUTH || state_n == WAIT) && fail_n != '0) ? 4'd1 : 4'd0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            prev <= 3'b111;
            cnt <= '0;
            fail <= '0;
            k <= '0;
            bad <= 1'b0;
            pw_data <= '0;
            pw_load <= 1'b0;
            user_id <= '0;
            mode_sel <= '0;
            btn_route <= '0;
            lcd_code <= '0;
            led_code <= '0;
            locked <= 1'b0;
        end else begin
            state <= state_n;
            prev <= buttons;
            cnt <= cnt_n;
            fail <= fail_n;
            k <= k_n;
            bad <= bad_n;
            pw_data <= pw_n;
            pw_load <= load_n;
            user_id <= uid_n;
            mode_sel <= sel_n;
            btn_route <= route_n;
            lcd_code <= lcd_n;
            led_code <= led_n;
            locked <= state_n == LOCKOUT;
        end
    end
endmodule

// File: tb/tb_session_controller.sv
// tb_session_controller: directed stimulus checked against a cycle-stamped session model
module tb_session_controller;
    localparam int L = 12, R = 6, IT = 30;
    logic clk = 0, rst = 0;
    logic [17:0] switches = '0;
    logic [2:0] buttons = '0;
    logic access_valid = 0, access_ok = 0;
    logic [1:0] mode_done = '0;
    logic [15:0] pw_data, user_id;
    logic pw_load, locked;
    logic [1:0] mode_sel;
    logic [2:0] btn_route, lcd_code;
    logic [3:0] led_code;
    always #5 clk = ~clk;
    session_controller #(.LOCKOUT_CYCLES(L), .RESP_TIMEOUT(R), .IDLE_TIMEOUT(IT)) dut (
        .clk(clk), .rst(rst), .switches(switches), .buttons(buttons),
        .access_valid(access_valid), .access_ok(access_ok), .mode_done(mode_done),
        .pw_data(pw_data), .pw_load(pw_load), .user_id(user_id), .mode_sel(mode_sel),
        .btn_route(btn_route), .lcd_code(lcd_code), .led_code(led_code), .locked(locked)
    );
    int vec = 0, bad = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask
    // model: phase 0 idle,1 auth,2 wait,3 lockout,4 menu,5 run; t0 = first cycle of current timed interval
    int cyc = 0, ph = 0, t0 = 0, fails = 0, mode = 0;
    bit badsel = 0, live = 0, m_load = 0;
    logic [2:0] lastb = 3'b111, r;
    logic [15:0] m_pw = '0, m_uid = '0;
    initial forever begin
        @(posedge clk);
        cyc++;
        live = 1;
        m_load = 0;
        if (!rst) begin
            ph = 0; fails = 0; mode = 0; badsel = 0; m_pw = '0; m_uid = '0; lastb = 3'b111;
        end else begin
            r = buttons & ~lastb;
            lastb = buttons;
            case (ph)
                0: if (r[0]) ph = 1;
                1: if (r[0]) begin m_pw = switches[15:0]; m_uid = switches[15:0]; m_load = 1; ph = 2; t0 = cyc + 1; end
                2: if (access_valid && access_ok) begin fails = 0; ph = 4; t0 = cyc + 1; badsel = 0; end
                   else if (access_valid || cyc - t0 == R) begin
                       fails++;
                       if (fails == 3) begin ph = 3; t0 = cyc + 1; end else ph = 1;
                   end
                3: if (cyc - t0 == L - 1) begin fails = 0; ph = 1; end
                4: begin
                    if (r != 0) begin t0 = cyc + 1; badsel = 0; end
                    if (r[0]) begin m_uid = '0; ph = 0; end
                    else if (r[1]) begin
                        if (switches[2:0] < 2) begin mode = int'(switches[2:0]); ph = 5; end else badsel = 1;
                    end else if (r[2]) begin mode = 0; ph = 5; end
                    else if (cyc - t0 == IT) begin m_uid = '0; ph = 0; end
                end
                default: if (mode_done[mode]) begin ph = 4; t0 = cyc + 1; badsel = 0; end
            endcase
        end
    end
    initial forever begin
        @(negedge clk);
        if (live) begin
            chk("pw_data", pw_data, m_pw);
            chk("pw_load", pw_load, m_load);
            chk("user_id", user_id, m_uid);
            chk("mode_sel", mode_sel, ph == 5 ? 1 << mode : 0);
            chk("btn_route", btn_route, ph == 5 ? mode + 1 : 0);
            chk("lcd_code", lcd_code, ph == 0 ? 0 : ph <= 2 ? 1 : ph == 3 ? 4 : ph == 4 ? (badsel ? 6 : 3) : 5);
            chk("led_code", led_code, ph == 3 ? 8 : ph >= 4 ? 2 : ((ph == 1 || ph == 2) && fails > 0) ? 1 : 0);
            chk("locked", locked, ph == 3);
        end
    end
    int load_cnt = 0, lock_cnt = 0;
    logic [15:0] pw_seen = '0;
    initial forever begin
        @(negedge clk);
        if (pw_load === 1'b1) begin load_cnt++; pw_seen = pw_data; end
        if (locked === 1'b1) lock_cnt++;
    end
    task automatic tick(int n); repeat (n) @(negedge clk); endtask
    task automatic press(int b); buttons[b] = 1; tick(1); buttons[b] = 0; tick(1); endtask
    task automatic respond(bit ok); access_valid = 1; access_ok = ok; tick(1); access_valid = 0; access_ok = 0; endtask
    initial begin
        tick(2);
        chk("rst_lcd", lcd_code, 0);
        chk("rst_sel", mode_sel, 0);
        chk("rst_uid", user_id, 0);
        chk("rst_load", pw_load, 0);
        rst = 1;
        tick(1);
        switches = 18'h3BEEF;
        press(0);
        chk("auth_lcd", lcd_code, 1);
        load_cnt = 0;
        press(0);
        tick(2);
        respond(1);
        chk("login_loads", load_cnt, 1);
        chk("login_pw", pw_seen, 16'hBEEF);
        chk("login_uid", user_id, 16'hBEEF);
        chk("login_led", led_code, 2);
        chk("login_lcd", lcd_code, 3);
        switches = 18'h1;
        press(1);
        chk("run1_sel", mode_sel, 2'b10);
        chk("run1_route", btn_route, 2);
        press(0);
        chk("run_btn_ignored", lcd_code, 5);
        mode_done = 2'b01; tick(1); mode_done = 0;
        chk("done0_ignored", mode_sel, 2'b10);
        mode_done = 2'b10; tick(1); mode_done = 0;
        chk("done1_sel", mode_sel, 0);
        chk("done1_lcd", lcd_code, 3);
        switches = 18'h5;
        press(1);
        chk("sel5_lcd", lcd_code, 6);
        chk("sel5_sel", mode_sel, 0);
        press(2);
        chk("replay_sel", mode_sel, 2'b01);
        chk("replay_route", btn_route, 1);
        mode_done = 2'b11; tick(1); mode_done = 0;
        buttons = 3'b011; tick(1); buttons = 0; tick(1);
        chk("simul_lcd", lcd_code, 0);
        chk("simul_uid", user_id, 0);
        press(0);
        for (int i = 0; i < 3; i++) begin
            press(0);
            if (i == 2) lock_cnt = 0;
            respond(0);
            if (i == 0) chk("reject1_led", led_code, 1);
        end
        chk("lock_locked", locked, 1);
        chk("lock_lcd", lcd_code, 4);
        chk("lock_led", led_code, 8);
        press(0);
        respond(1);
        press(1);
        tick(L);
        chk("lock_cycles", lock_cnt, L);
        chk("unlock_lcd", lcd_code, 1);
        chk("unlock_led", led_code, 0);
        for (int i = 0; i < 2; i++) begin press(0); respond(0); end
        chk("two_rej_locked", locked, 0);
        press(0);
        respond(1);
        chk("accept_led", led_code, 2);
        press(0);
        press(0);
        chk("fails_cleared", led_code, 0);
        press(0);
        tick(R - 1);
        chk("pre_timeout_led", led_code, 0);
        tick(1);
        chk("timeout_led", led_code, 1);
        chk("timeout_lcd", lcd_code, 1);
        press(0);
        tick(R - 1);
        respond(1);
        chk("valid_on_timeout", lcd_code, 3);
        tick(IT);
        chk("pre_idle_lcd", lcd_code, 3);
        tick(1);
        chk("idle_lcd", lcd_code, 0);
        chk("idle_uid", user_id, 0);
        buttons[0] = 1; rst = 0;
        tick(2);
        rst = 1;
        tick(3);
        chk("held_no_edge", lcd_code, 0);
        buttons = 0;
        tick(1);
        press(0);
        load_cnt = 0;
        buttons[0] = 1; rst = 0;
        tick(1);
        chk("drop_load", load_cnt, 0);
        chk("drop_lcd", lcd_code, 0);
        rst = 1; buttons = 0;
        tick(2);
        press(0);
        switches = 18'h1234;
        press(0);
        respond(1);
        switches = 18'h1;
        press(1);
        chk("pre_rst_sel", mode_sel, 2'b10);
        rst = 0;
        tick(1);
        chk("rst_run_sel", mode_sel, 0);
        chk("rst_run_route", btn_route, 0);
        chk("rst_run_lcd", lcd_code, 0);
        rst = 1;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/session_controller.md
# session_controller

Top-level session sequencer for the console. It arbitrates player access among the password checker and NUM_MODES application modes (game, scoreboard, …). It gates the shared push-buttons, drives LCD/LED status codes, and enforces retry lockout plus response and inactivity timeouts. It sits between the board I/O and the access-control, game and scoreboard blocks, and replaces the fixed three-target controller with a parametrised one.

## Interface
Parameters:
- ID_W, 16: width of password/user-ID field taken from switches[ID_W-1:0].
- SW_W, 18: switch bus width; must be ≥ ID_W and ≥ MSEL_W.
- NUM_MODES, 2: number of application modes, 1..7.
- MSEL_W, 3: switch bits used for menu selection, switches[MSEL_W-1:0].
- MAX_TRIES, 3: consecutive failed logins before lockout, ≥1.
- LOCKOUT_CYCLES, 1000: lockout duration, ≥1.
- RESP_TIMEOUT, 255: maximum wait for access_valid, ≥1.
- IDLE_TIMEOUT, 100000: MENU inactivity logout, ≥1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-low reset.
- switches, input, SW_W: raw switches.
- buttons, input, 3: debounced, level, active-high.
- access_valid, input, 1: one-cycle pulse, result of access_ok is valid.
- access_ok, input, 1: 1 = password accepted; sampled only with access_valid.
- mode_done, input, NUM_MODES: per-mode completion pulse.
- pw_data, output, ID_W: password word to checker.
- pw_load, output, 1: one-cycle load strobe.
- user_id, output, ID_W: logged-in user ID to scoreboard.
- mode_sel, output, NUM_MODES: one-hot active mode, 0 when none.
- btn_route, output, 3: button owner; 0 = controller, k+1 = mode k.
- lcd_code, output, 3: LCD screen select.
- led_code, output, 4: LED pattern select.
- locked, output, 1: high during LOCKOUT.

## Operation
- Button edges: rise[i] = buttons[i] & ~prev[i]. prev resets to 3'b111, so a button held through reset produces no edge.
- States: IDLE, AUTH, WAIT, LOCKOUT, MENU, RUN.
- IDLE: on rise[0], go to AUTH. Outputs: lcd 0, led 0, btn_route 0.
- AUTH: on rise[0], latch pw_data and user_id ← switches[ID_W-1:0], assert pw_load for exactly one cycle, go to WAIT. Outputs: lcd 1; led 1 if fail_cnt>0, else 0.
- WAIT: a response counter runs.
  - access_valid & access_ok: fail_cnt←0, go to MENU.
  - access_valid & ~access_ok, or counter reaching RESP_TIMEOUT: fail_cnt+1. If the result equals MAX_TRIES, go to LOCKOUT; otherwise go to AUTH.
  - Buttons are ignored. lcd 1.
- LOCKOUT: counts LOCKOUT_CYCLES, then fail_cnt←0 and go to AUTH. Outputs: locked 1, lcd 4, led 8. All inputs are ignored.
- MENU: outputs lcd 3, led 2.
  - rise[0]: logout. user_id←0, go to IDLE.
  - rise[1]: k = switches[MSEL_W-1:0]. If k<NUM_MODES, go to RUN with mode k. Otherwise stay in MENU with lcd 6 until the next edge.
  - rise[2]: go to RUN with mode 0 (quick replay).
  - Priority when several edges coincide: 0 > 1 > 2.
  - The idle counter clears on any rise. When it reaches IDLE_TIMEOUT, logout to IDLE.
- RUN: outputs mode_sel = one-hot(k), btn_route = k+1, lcd 5, led 2.
  - mode_done[k] returns to MENU, with mode_sel cleared in the same transition.
  - mode_done of other bits is ignored.
  - Controller buttons are ignored.
- Reset values: state IDLE, all outputs 0, all counters 0, fail_cnt 0, prev 3'b111.
- Reset mid-operation returns to IDLE the next edge. A pending pw_load is dropped.

## Timing
- All outputs are registered.
- AUTH edge sampled at cycle n: pw_data, user_id and pw_load are valid at n+1, and the state is WAIT at n+1.
- access_valid at cycle n: state changes at n+1.
- The response counter starts at 0 on WAIT entry. Timeout is taken at cycle RESP_TIMEOUT after entry. If access_valid arrives on the timeout cycle, the response wins.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles. locked falls in the same cycle AUTH is entered.
- MENU→RUN: one cycle after the edge. mode_done to MENU: one cycle.
- Counters saturate. Width is $clog2(param+1).

## Test plan
- Login success: rst low for 2 cycles, then rise[0], set switches=16'hBEEF, rise[0], then access_valid/ok 3 cycles later. Expect pw_load high for exactly 1 cycle with pw_data=16'hBEEF, then state MENU, led 2, user_id 16'hBEEF.
- Lockout: MAX_TRIES=3, three rejects. Expect locked high for LOCKOUT_CYCLES, lcd 4, inputs ignored, then AUTH with fail_cnt 0. Also check two rejects followed by an accept: fail_cnt 0 and no lockout.
- Response timeout: no access_valid. Expect a fail counted at cycle RESP_TIMEOUT. A valid arriving on the same cycle takes priority.
- Mode dispatch: NUM_MODES=2.
  - Select 1 with rise[1]: mode_sel 2'b10, btn_route 2.
  - mode_done[0] is ignored; mode_done[1] returns to MENU.
  - Select 5: lcd 6, no RUN.
- Simultaneous edges and inactivity: rise[0] and rise[1] together lead to IDLE with user_id 0. No edge for IDLE_TIMEOUT cycles in MENU also leads to IDLE.
- Reset boundaries: button held during reset gives no transition after release of rst. Reset asserted in RUN gives mode_sel 0 and IDLE on the next edge.
